// File: rtl/id_ex_stage_pkg.sv
// Shared constants and decode helper for the ID/EX stage.
package id_ex_stage_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_AW_DEF = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        BSelReg,
        BSelSext,
        BSelZext
    } b_sel_e;

    typedef struct packed {
        b_sel_e b_sel;
        logic   dest_rd;
        logic   wr;
    } dec_t;

    // Unknown opcodes fall through as a NOP that reads rt and writes nothing.
    function automatic dec_t decode_op(logic [5:0] op);
        dec_t d;
        d = '{b_sel: BSelReg, dest_rd: 1'b0, wr: 1'b0};
        case (op)
            OP_RTYPE:              d = '{b_sel: BSelReg,  dest_rd: 1'b1, wr: 1'b1};
            OP_ADDI, OP_SLTI, OP_LW: d = '{b_sel: BSelSext, dest_rd: 1'b0, wr: 1'b1};
            OP_ANDI, OP_ORI:       d = '{b_sel: BSelZext, dest_rd: 1'b0, wr: 1'b1};
            OP_SW:                 d = '{b_sel: BSelSext, dest_rd: 1'b0, wr: 1'b0};
            OP_BEQ:                d = '{b_sel: BSelReg,  dest_rd: 1'b0, wr: 1'b0};
            default:               d = '{b_sel: BSelReg,  dest_rd: 1'b0, wr: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Fetch-side, writeback, flush and ALU-side signals of the ID/EX stage.
interface id_ex_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
);

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        opcode;
    logic [5:0]        func_field;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [DATA_W-1:0] st_data;
    logic [REG_AW-1:0] dest;
    logic              reg_write;

    modport master (
        output in_valid, instr, wb_en, wb_addr, wb_data, flush, out_ready,
        input  in_ready, out_valid, opcode, func_field, A, B, st_data, dest, reg_write
    );

    modport slave (
        input  in_valid, instr, wb_en, wb_addr, wb_data, flush, out_ready,
        output in_ready, out_valid, opcode, func_field, A, B, st_data, dest, reg_write
    );

endinterface

// File: rtl/id_ex_stage_reg_file.sv
// Register file: two async read ports, one write port, r0 hardwired to zero.
// WB_BYPASS_EN forwards a same-cycle writeback onto the read ports.
module id_ex_stage_reg_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [REG_AW-1:0] rt_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o
);

    localparam int unsigned NumRegs = 1 << REG_AW;

    logic [DATA_W-1:0] regs_q [NumRegs];
    logic              wr_active;

    assign wr_active = wb_en_i && (wb_addr_i != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_active) begin
            regs_q[wb_addr_i] <= wb_data_i;
        end
    end

    always_comb begin
        rs_data_o = (rs_addr_i == '0) ? '0 : regs_q[rs_addr_i];
        rt_data_o = (rt_addr_i == '0) ? '0 : regs_q[rt_addr_i];
`ifdef WB_BYPASS_EN
        if (wr_active && (wb_addr_i == rs_addr_i)) rs_data_o = wb_data_i;
        if (wr_active && (wb_addr_i == rt_addr_i)) rt_data_o = wb_data_i;
`endif
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/register-read stage with a valid/ready ID/EX pipeline register.
// Optional WB_BYPASS_EN macro enables writeback-to-read forwarding in the reg file.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);

    logic [REG_AW-1:0] rs, rt, rd;
    logic [15:0]       imm;
    logic [DATA_W-1:0] rs_data, rt_data;
    logic [DATA_W-1:0] b_sel_val;
    dec_t              dec;
    logic              in_ready, load;
    logic              unused_shamt;

    logic              out_valid_q, out_valid_d;
    logic [5:0]        opcode_q, opcode_d;
    logic [5:0]        func_q, func_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] st_data_q, st_data_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic              reg_write_q, reg_write_d;

    assign rs           = REG_AW'(bus.instr[25:21]);
    assign rt           = REG_AW'(bus.instr[20:16]);
    assign rd           = REG_AW'(bus.instr[15:11]);
    assign imm          = bus.instr[15:0];
    assign unused_shamt = ^bus.instr[10:6];
    assign dec          = decode_op(bus.instr[31:26]);

    id_ex_stage_reg_file #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .wb_en_i   (bus.wb_en),
        .wb_addr_i (bus.wb_addr),
        .wb_data_i (bus.wb_data),
        .rs_addr_i (rs),
        .rt_addr_i (rt),
        .rs_data_o (rs_data),
        .rt_data_o (rt_data)
    );

    always_comb begin
        b_sel_val = rt_data;
        case (dec.b_sel)
            BSelSext: b_sel_val = {{(DATA_W-16){imm[15]}}, imm};
            BSelZext: b_sel_val = {{(DATA_W-16){1'b0}}, imm};
            default:  b_sel_val = rt_data;
        endcase
    end

    assign in_ready = !out_valid_q || bus.out_ready;
    assign load     = bus.in_valid && in_ready && !bus.flush;

    // Flush wins over a same-cycle load; the offered instruction is dropped.
    always_comb begin
        out_valid_d = out_valid_q;
        opcode_d    = opcode_q;
        func_d      = func_q;
        a_d         = a_q;
        b_d         = b_q;
        st_data_d   = st_data_q;
        dest_d      = dest_q;
        reg_write_d = reg_write_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
            opcode_d    = bus.instr[31:26];
            func_d      = bus.instr[5:0];
            a_d         = rs_data;
            b_d         = b_sel_val;
            st_data_d   = rt_data;
            dest_d      = dec.dest_rd ? rd : rt;
            reg_write_d = dec.wr && !(dec.dest_rd && (rd == '0));
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            func_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            st_data_q   <= '0;
            dest_q      <= '0;
            reg_write_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            opcode_q    <= opcode_d;
            func_q      <= func_d;
            a_q         <= a_d;
            b_q         <= b_d;
            st_data_q   <= st_data_d;
            dest_q      <= dest_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.opcode     = opcode_q;
    assign bus.func_field = func_q;
    assign bus.A          = a_q;
    assign bus.B          = b_q;
    assign bus.st_data    = st_data_q;
    assign bus.dest       = dest_q;
    assign bus.reg_write  = reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow WB_BYPASS_EN.
module tb_id_ex_stage;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

    id_ex_stage #(
        .DATA_W (32),
        .REG_AW (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    logic [31:0] exp_byp;

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.wb_en     = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_A", bus.A, 32'd0);
        chk("rst_B", bus.B, 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;

        // 1: writeback r1=5, r2=7, then R-type add
        tick();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'd5;
        tick();
        bus.wb_addr = 5'd2; bus.wb_data = 32'd7;
        tick();
        bus.wb_en = 1'b0;
        bus.in_valid = 1'b1; bus.instr = rtype(1, 2, 3, 6'h20);
        tick();
        bus.in_valid = 1'b0;
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_A", bus.A, 32'd5);
        chk("add_B", bus.B, 32'd7);
        chk("add_dest", 32'(bus.dest), 32'd3);
        chk("add_rw", 32'(bus.reg_write), 32'd1);
        chk("add_func", 32'(bus.func_field), 32'h20);
        chk("add_st", bus.st_data, 32'd7);

        // 2: immediates and other opcodes
        bus.in_valid = 1'b1; bus.instr = itype(6'h08, 1, 4, 16'hFFFF);
        tick();
        chk("addi_B", bus.B, 32'hFFFF_FFFF);
        chk("addi_A", bus.A, 32'd5);
        chk("addi_dest", 32'(bus.dest), 32'd4);
        chk("addi_op", 32'(bus.opcode), 32'h08);
        bus.instr = itype(6'h0D, 1, 6, 16'hFFFF);
        tick();
        chk("ori_B", bus.B, 32'h0000_FFFF);
        chk("ori_dest", 32'(bus.dest), 32'd6);
        chk("ori_rw", 32'(bus.reg_write), 32'd1);
        bus.instr = itype(6'h2B, 2, 1, 16'h0010);
        tick();
        chk("sw_B", bus.B, 32'h10);
        chk("sw_st", bus.st_data, 32'd5);
        chk("sw_rw", 32'(bus.reg_write), 32'd0);
        bus.instr = itype(6'h04, 1, 2, 16'h0003);
        tick();
        chk("beq_B", bus.B, 32'd7);
        chk("beq_rw", 32'(bus.reg_write), 32'd0);
        bus.instr = rtype(1, 2, 0, 6'h20);
        tick();
        chk("rd0_rw", 32'(bus.reg_write), 32'd0);
        bus.instr = itype(6'h3F, 2, 1, 16'h1234);
        tick();
        chk("nop_B", bus.B, 32'd5);
        chk("nop_rw", 32'(bus.reg_write), 32'd0);

        // 3: stall for two cycles with a pending instruction
        bus.instr = itype(6'h0C, 2, 7, 16'h8001);
        tick();
        chk("andi_B", bus.B, 32'h0000_8001);
        bus.out_ready = 1'b0;
        bus.instr = itype(6'h0A, 1, 8, 16'h8000);
        #1;
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("stall1_valid", 32'(bus.out_valid), 32'd1);
        chk("stall1_B", bus.B, 32'h0000_8001);
        chk("stall1_dest", 32'(bus.dest), 32'd7);
        tick();
        chk("stall2_B", bus.B, 32'h0000_8001);
        chk("stall2_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("slti_B", bus.B, 32'hFFFF_8000);
        chk("slti_dest", 32'(bus.dest), 32'd8);
        chk("slti_op", 32'(bus.opcode), 32'h0A);
        tick();
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        // 4: flush beats a same-cycle load, and kills a held entry
        bus.in_valid = 1'b1; bus.flush = 1'b1; bus.instr = itype(6'h08, 2, 9, 16'h0003);
        tick();
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        chk("flush_drop_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_drop_B", bus.B, 32'hFFFF_8000);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b1;
        chk("flush_pre_valid", 32'(bus.out_valid), 32'd1);
        tick();
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        chk("flush_held_valid", 32'(bus.out_valid), 32'd0);

        // 5: r0 ignores writes; same-cycle writeback/read
        bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hDEAD;
        tick();
        bus.wb_en = 1'b0;
        bus.in_valid = 1'b1; bus.instr = rtype(0, 0, 1, 6'h20);
        tick();
        chk("r0_A", bus.A, 32'd0);
        chk("r0_B", bus.B, 32'd0);
        bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'd9;
        bus.instr = itype(6'h08, 5, 10, 16'h0000);
`ifdef WB_BYPASS_EN
        exp_byp = 32'd9;
`else
        exp_byp = 32'd0;
`endif
        tick();
        bus.wb_en = 1'b0;
        chk("bypass_A", bus.A, exp_byp);
        tick();
        bus.in_valid = 1'b0;
        chk("r5_after_A", bus.A, 32'd9);

        // 6: reset in the middle of a stall
        bus.in_valid = 1'b1; bus.instr = rtype(1, 2, 3, 6'h20);
        tick();
        chk("pre_rst_A", bus.A, 32'd5);
        bus.out_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_A", bus.A, 32'd0);
        chk("midrst_B", bus.B, 32'd0);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b1; bus.instr = rtype(1, 2, 3, 6'h20);
        tick();
        bus.in_valid = 1'b0;
        chk("postrst_valid", 32'(bus.out_valid), 32'd1);
        chk("postrst_A", bus.A, 32'd0);
        chk("postrst_B", bus.B, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
